// File: rtl/ms_mul_issue_ctrl.sv
// ms_mul_issue_ctrl: operand-issue and result-capture stage in front of ms_serial_by2_mul.
// Buffers operand tuples in a small FIFO. Issues one tuple at a time to the multiplier
// and holds mul_en until mul_done. Returns each product over a valid/ready handshake.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    operand tuple input handshake (in_ready = FIFO not full)
//   mul_en/mul_data          enable and registered operands to the multiplier
//   mul_done/mul_result      multiplier completion and product
//   out_valid/out_ready/out_data product output handshake
//   busy                     FSM not idle or FIFO non-empty
//   ops_done                 completed-operation counter (wraps)
//   mul_timeout              sticky watchdog flag (only with MUL_TIMEOUT_EN)
//
// Optional feature macro: MUL_TIMEOUT_EN. When defined, RUN is aborted after
// TIMEOUT_CYCLES cycles without mul_done. The aborted operation returns a zero product.
module ms_mul_issue_ctrl #(
    parameter int unsigned DATA_WIDTH     = 5,
    parameter int unsigned NUM_INPUTS     = 2,
    parameter int unsigned PROD_WIDTH     = NUM_INPUTS * DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [NUM_INPUTS-1:0],
    output logic                  mul_en,
    output logic [DATA_WIDTH-1:0] mul_data [NUM_INPUTS-1:0],
    input  logic                  mul_done,
    input  logic [PROD_WIDTH-1:0] mul_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PROD_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [15:0]           ops_done
`ifdef MUL_TIMEOUT_EN
    ,
    output logic                  mul_timeout
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] tuple_t;

    tuple_t                in_tuple_c;
    tuple_t                mem_q [FIFO_DEPTH];
    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mul_en_q, mul_en_d;
    tuple_t                mul_data_q, mul_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [PROD_WIDTH-1:0] out_data_q, out_data_d;
    logic                  busy_q, busy_d;
    logic [15:0]           ops_done_q, ops_done_d;
    logic                  push_c, pop_c;

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                  mul_timeout_q, mul_timeout_d;
`else
    logic                  unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Unpacked port arrays <-> packed internal tuples
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_tuple
        assign in_tuple_c[g] = in_data[g];
        assign mul_data[g]   = mul_data_q[g];
    end

    // Push is gated by the registered not-full flag, so a full FIFO refuses even during a pop
    assign push_c = in_valid && in_ready_q;

    // FIFO storage; contents need no reset because the count governs validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_tuple_c;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        mul_en_d    = 1'b0;
        mul_data_d  = mul_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ops_done_d  = ops_done_q;
        pop_c       = 1'b0;
`ifdef MUL_TIMEOUT_EN
        tmo_cnt_d     = '0;
        mul_timeout_d = mul_timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    pop_c      = 1'b1;
                    mul_data_d = mem_q[rd_ptr_q];
                    state_d    = ST_RUN;
                end
            end
            // mul_en rises one cycle after entering RUN and falls on the done edge
            ST_RUN: begin
                if (mul_done) begin
                    out_data_d  = mul_result;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
`ifdef MUL_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    out_data_d    = '0;
                    out_valid_d   = 1'b1;
                    mul_timeout_d = 1'b1;
                    state_d       = ST_HOLD;
                end
                else begin
                    mul_en_d  = 1'b1;
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`else
                else begin
                    mul_en_d = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pointers wrap naturally because FIFO_DEPTH is a power of two
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        in_ready_d = (cnt_d != CNT_W'(FIFO_DEPTH));
        busy_d     = (state_d != ST_IDLE) || (cnt_d != '0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            ops_done_q  <= '0;
`ifdef MUL_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            mul_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            mul_en_q    <= mul_en_d;
            mul_data_q  <= mul_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            ops_done_q  <= ops_done_d;
`ifdef MUL_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            mul_timeout_q <= mul_timeout_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_en    = mul_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;
`ifdef MUL_TIMEOUT_EN
    assign mul_timeout = mul_timeout_q;
`endif

endmodule

// File: tb/tb_ms_mul_issue_ctrl.sv
// Self-checking bench for ms_mul_issue_ctrl: behavioural multiplier model,
// scoreboard of expected products, table of vectors plus directed corner cases.
module tb_ms_mul_issue_ctrl;

    localparam int unsigned DW = 5;
    localparam int unsigned NI = 2;
    localparam int unsigned PW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data [NI-1:0];
    logic          mul_en;
    logic [DW-1:0] mul_data [NI-1:0];
    logic          mul_done;
    logic [PW-1:0] mul_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_data;
    logic          busy;
    logic [15:0]   ops_done;
`ifdef MUL_TIMEOUT_EN
    logic          mul_timeout;
`endif

    ms_mul_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mul_en     (mul_en),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .ops_done   (ops_done)
`ifdef MUL_TIMEOUT_EN
        ,
        .mul_timeout(mul_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: done once mul_en has been high for mul_lat cycles
    int mul_lat   = 3;
    bit mul_stall = 1'b0;
    bit spur_done = 1'b0;
    int en_cnt    = 0;

    always @(posedge clk) en_cnt <= mul_en ? en_cnt + 1 : 0;

    assign mul_done   = spur_done || (mul_en && !mul_stall && en_cnt >= mul_lat);
    assign mul_result = spur_done ? 10'h3FF : PW'(mul_data[0]) * PW'(mul_data[1]);

    int            checks   = 0;
    int            failures = 0;
    int            exp_ops  = 0;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] sb_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    // Scoreboard: every accepted product is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out act=%0d req=none", out_data);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_product", 32'(out_data), 32'(sb_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int b, input int e);
        int n;
        n = 0;
        in_data[0] = DW'(a);
        in_data[1] = DW'(b);
        in_valid   = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_accept", 32'(in_ready), 1);
        else exp_q.push_back(PW'(e));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || out_valid || exp_q.size() != 0) && n < 500) begin
            tick();
            n++;
        end
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check({name, "_valid"}, 32'(out_valid), 1);
    endtask

    typedef struct {
        int a;
        int b;
        int lat;
        int prod;
    } vec_t;
    vec_t vecs [6];

    initial begin
        int n;
        int bad;
        logic [PW-1:0] held;

        vecs[0] = '{31, 31, 0, 961};
        vecs[1] = '{0,  17, 2, 0};
        vecs[2] = '{1,  31, 5, 31};
        vecs[3] = '{12, 13, 1, 156};
        vecs[4] = '{16, 2,  7, 32};
        vecs[5] = '{31, 0,  3, 0};
        in_data[0] = '0;
        in_data[1] = '0;

        // Reset state
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mul_en", 32'(mul_en), 0);
        check("rst_mul_data", 32'(mul_data[0]), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ops_done", 32'(ops_done), 0);
`ifdef MUL_TIMEOUT_EN
        check("rst_mul_timeout", 32'(mul_timeout), 0);
`endif
        rst = 1'b1;
        tick();
        check("rel_in_ready", 32'(in_ready), 1);

        // Single tuple {3,7}, done 10 cycles after mul_en rises
        mul_lat = 10;
        push(3, 7, 21);
        tick();
        check("t1_en_load", 32'(mul_en), 0);
        check("t1_data0", 32'(mul_data[0]), 3);
        check("t1_data1", 32'(mul_data[1]), 7);
        tick();
        check("t1_en_rise", 32'(mul_en), 1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!mul_en) break;
            n++;
        end
        check("t1_en_cycles", n, 11);
        check("t1_out_valid", 32'(out_valid), 1);
        check("t1_out_data", 32'(out_data), 21);
        wait_idle("t1");
        exp_ops = 1;
        check("t1_ops_done", 32'(ops_done), exp_ops);

        // Table of vectors with varied latencies
        for (int i = 0; i < 6; i++) begin
            mul_lat = vecs[i].lat;
            push(vecs[i].a, vecs[i].b, vecs[i].prod);
            wait_idle("vec");
            exp_ops++;
            check("vec_ops_done", 32'(ops_done), exp_ops);
        end

        // Five tuples with the multiplier stalled: FIFO fills, full blocks push
        mul_stall = 1'b1;
        mul_lat   = 2;
        push(2, 3, 6);
        push(4, 5, 20);
        push(31, 31, 961);
        push(0, 9, 0);
        push(1, 1, 1);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_busy", 32'(busy), 1);
        in_data[0] = 5'd7;
        in_data[1] = 5'd7;
        in_valid   = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_ready) bad++;
        end
        in_valid = 1'b0;
        check("full_hold_ready", bad, 0);
        mul_stall = 1'b0;
        wait_idle("burst");
        exp_ops += 5;
        check("burst_ops_done", 32'(ops_done), exp_ops);

        // Output back-pressure for 20 cycles with a second tuple queued
        out_ready = 1'b0;
        mul_lat   = 4;
        push(5, 6, 30);
        push(2, 2, 4);
        wait_out("bp");
        held = out_data;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_data !== held || mul_en || !out_valid) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_data", 32'(out_data), 30);
        out_ready = 1'b1;
        wait_idle("bp");
        exp_ops += 2;
        check("bp_ops_done", 32'(ops_done), exp_ops);

        // Spurious mul_done in IDLE
        spur_done = 1'b1;
        tick(); tick();
        spur_done = 1'b0;
        tick();
        check("spur_idle_valid", 32'(out_valid), 0);
        check("spur_idle_busy", 32'(busy), 0);
        check("spur_idle_data", 32'(out_data), 4);

        // Spurious mul_done in HOLD
        out_ready = 1'b0;
        mul_lat   = 1;
        push(4, 4, 16);
        wait_out("spur_hold");
        spur_done = 1'b1;
        tick(); tick();
        spur_done = 1'b0;
        check("spur_hold_data", 32'(out_data), 16);
        check("spur_hold_valid", 32'(out_valid), 1);
        check("spur_hold_en", 32'(mul_en), 0);
        out_ready = 1'b1;
        wait_idle("spur_hold");
        exp_ops++;
        check("spur_ops_done", 32'(ops_done), exp_ops);

        // Reset during RUN with two tuples queued
        mul_stall = 1'b1;
        push(3, 3, 9);
        push(4, 4, 16);
        push(5, 5, 25);
        n = 0;
        while (!mul_en && n < 50) begin
            tick();
            n++;
        end
        check("mr_en_before", 32'(mul_en), 1);
        rst = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready), 0);
        check("mr_mul_en", 32'(mul_en), 0);
        check("mr_out_valid", 32'(out_valid), 0);
        check("mr_out_data", 32'(out_data), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_ops_done", 32'(ops_done), 0);
        exp_q.delete();
        exp_ops = 0;
        tick(); tick();
        rst       = 1'b1;
        mul_stall = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid || mul_en) bad++;
        end
        check("mr_no_out", bad, 0);
        check("mr_busy_after", 32'(busy), 0);
        check("mr_ready_after", 32'(in_ready), 1);

`ifdef MUL_TIMEOUT_EN
        // Multiplier never completes: watchdog returns a zero product
        mul_stall = 1'b1;
        push(9, 9, 0);
        wait_out("tmo");
        check("tmo_data", 32'(out_data), 0);
        check("tmo_flag", 32'(mul_timeout), 1);
        mul_stall = 1'b0;
        mul_lat   = 2;
        wait_idle("tmo");
        push(2, 5, 10);
        wait_idle("tmo_next");
        exp_ops += 2;
        check("tmo_sticky", 32'(mul_timeout), 1);
        check("tmo_ops_done", 32'(ops_done), exp_ops);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
